// File: rtl/param_down_timer.sv
// param_down_timer: loadable down-counter/timer built from cascaded SEG_W-bit segments.
// Define PARAM_TIMER_RELOAD_EN to add an auto-reload register for periodic operation.
module param_down_timer #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic [1:0]       state_dbg
);

  localparam int NSEG = WIDTH / SEG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state;
  logic [NSEG:0]    borrow;
  logic [WIDTH-1:0] q_dec;
  logic [WIDTH-1:0] term_q;
  logic             q_zero;
  logic             q_one;
  logic             accept_load;
  logic             reload_nz;

  // Handshake: a load transfers when load_valid && load_ready at a rising edge.
  // load_ready is high exactly in IDLE and PAUSE; the requester holds load_valid until accepted.
  assign accept_load = load_valid && load_ready;
  assign q_one       = (q == WIDTH'(1));
  assign q_zero      = borrow[NSEG];
  assign state_dbg   = state;

  // Segment k borrows only when every lower registered segment reads zero.
  always_comb begin
    borrow    = '0;
    borrow[0] = 1'b1;
    q_dec     = q;
    for (int k = 0; k < NSEG; k++) begin
      borrow[k+1] = borrow[k] && (q[k*SEG_W +: SEG_W] == '0);
      if (borrow[k]) q_dec[k*SEG_W +: SEG_W] = q[k*SEG_W +: SEG_W] - SEG_W'(1);
    end
  end

`ifdef PARAM_TIMER_RELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      reload <= '0;
    end else if (accept_load) begin
      reload <= load_value;
    end
  end

  assign reload_nz = (reload != '0);
  assign term_q    = reload;
`else
  assign reload_nz = 1'b0;
  assign term_q    = '0;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      q          <= '0;
      busy       <= 1'b0;
      tc         <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      tc <= 1'b0;
      case (state)
        IDLE, PAUSE: begin
          // A load wins over a simultaneous start; start is re-evaluated next cycle.
          if (accept_load) begin
            q <= load_value;
          end else if (start && !stop && !q_zero) begin
            state      <= RUN;
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state      <= PAUSE;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else if (q_one) begin
            tc <= 1'b1;
            q  <= term_q;
            if (!reload_nz) begin
              state      <= IDLE;
              busy       <= 1'b0;
              load_ready <= 1'b1;
            end
          end else begin
            q <= q_dec;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_down_timer.sv
// tb_param_down_timer: scoreboard bench for param_down_timer; each step pushes a stimulus
// and the expected {load_ready, busy, tc, q} after the following rising edge.
module tb_param_down_timer;

  localparam int W     = 32;
  localparam int SEG_W = 8;
  localparam int EW    = W + 3;

  typedef struct packed {
    logic         lv;
    logic [W-1:0] val;
    logic         st;
    logic         sp;
  } stim_t;

  logic         clk;
  logic         rst_;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         load_ready;
  logic         start;
  logic         stop;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;
  logic [1:0]   state_dbg;

  stim_t         stim_q[$];
  logic [EW-1:0] exp_q[$];
  int            total;
  int            bad;

  param_down_timer #(.WIDTH(W), .SEG_W(SEG_W)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .start      (start),
    .stop       (stop),
    .q          (q),
    .busy       (busy),
    .tc         (tc),
    .state_dbg  (state_dbg)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input stim_t s);
    load_valid = s.lv;
    load_value = s.val;
    start      = s.st;
    stop       = s.sp;
    tick();
    load_valid = 1'b0;
    load_value = '0;
    start      = 1'b0;
    stop       = 1'b0;
  endtask

  task automatic step(input logic lv, input logic [W-1:0] val, input logic st, input logic sp,
                      input logic e_lr, input logic e_busy, input logic e_tc, input logic [W-1:0] e_q);
    stim_q.push_back(stim_t'({lv, val, st, sp}));
    exp_q.push_back({e_lr, e_busy, e_tc, e_q});
  endtask

  task automatic test_reset();
    rst_       = 1'b0;
    load_valid = 1'b0;
    load_value = '0;
    start      = 1'b0;
    stop       = 1'b0;
    repeat (3) tick();
    total++;
    if (q !== '0) begin bad++; $display("FAIL reset_q: got %h exp 0", q); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
    total++;
    if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc: got %b exp 0", tc); end
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready: got %b exp 1", load_ready); end
    rst_ = 1'b1;
    tick();
  endtask

  task automatic test_count5();
    logic [EW-1:0] e;
    int i = 0;
    int tc_idx = -1;
    int tc_n = 0;
    step(1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
    for (int v = 4; v >= 1; v--) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(v));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if ({load_ready, busy, tc, q} !== e) begin
        bad++;
        $display("FAIL count5 step %0d: got lr/busy/tc/q=%b/%b/%b/%h exp %b/%b/%b/%h",
                 i, load_ready, busy, tc, q, e[EW-1], e[EW-2], e[EW-3], e[W-1:0]);
      end
      if (tc === 1'b1) begin
        tc_n++;
        if (tc_idx < 0) tc_idx = i;
      end
      i++;
    end
    // Start was applied at step index 1; count cycles from that edge inclusive.
    total++;
    if (tc_idx - 1 + 1 !== 6) begin bad++; $display("FAIL count5_latency: got %0d exp 6", tc_idx); end
    total++;
    if (tc_n !== 1) begin bad++; $display("FAIL count5_tc_count: got %0d exp 1", tc_n); end
  endtask

  task automatic test_borrow();
    logic [EW-1:0] e;
    int i = 0;
    step(1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0100_0000);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0100_0000);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00FF_FFFF);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00FF_FFFF);
    step(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_0000);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0001_0000);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_FFFF);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_FFFF);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if ({load_ready, busy, tc, q} !== e) begin
        bad++;
        $display("FAIL borrow step %0d: got lr/busy/tc/q=%b/%b/%b/%h exp %b/%b/%b/%h",
                 i, load_ready, busy, tc, q, e[EW-1], e[EW-2], e[EW-3], e[W-1:0]);
      end
      i++;
    end
  endtask

  task automatic test_pause();
    logic [EW-1:0] e;
    int i = 0;
    int tc_n = 0;
    step(1'b1, 32'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd10);
    for (int v = 9; v >= 7; v--) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(v));
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd7);
    repeat (20) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd7);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7);
    for (int v = 6; v >= 1; v--) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(v));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    // Stop exactly at q == 1 must suppress the terminal count.
    step(1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if ({load_ready, busy, tc, q} !== e) begin
        bad++;
        $display("FAIL pause step %0d: got lr/busy/tc/q=%b/%b/%b/%h exp %b/%b/%b/%h",
                 i, load_ready, busy, tc, q, e[EW-1], e[EW-2], e[EW-3], e[W-1:0]);
      end
      if (tc === 1'b1) tc_n++;
      i++;
    end
    total++;
    if (tc_n !== 1) begin bad++; $display("FAIL pause_tc_count: got %0d exp 1", tc_n); end
  endtask

  task automatic test_edges();
    logic [EW-1:0] e;
    int i = 0;
    step(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3);
    // load_valid held through RUN is only taken once the count returns to IDLE.
    step(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2);
    step(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);
    step(1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hAA);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAA);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAA);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAA);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAA);
    step(1'b1, 32'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if ({load_ready, busy, tc, q} !== e) begin
        bad++;
        $display("FAIL edges step %0d: got lr/busy/tc/q=%b/%b/%b/%h exp %b/%b/%b/%h",
                 i, load_ready, busy, tc, q, e[EW-1], e[EW-2], e[EW-3], e[W-1:0]);
      end
      i++;
    end
  endtask

  task automatic test_async_reset();
    logic [EW-1:0] e;
    int i = 0;
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20);
    for (int k = 1; k <= 16; k++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(32'h20 - k));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if ({load_ready, busy, tc, q} !== e) begin
        bad++;
        $display("FAIL async_reset step %0d: got lr/busy/tc/q=%b/%b/%b/%h exp %b/%b/%b/%h",
                 i, load_ready, busy, tc, q, e[EW-1], e[EW-2], e[EW-3], e[W-1:0]);
      end
      i++;
    end
    #2 rst_ = 1'b0;
    #1;
    total++;
    if (q !== '0) begin bad++; $display("FAIL async_reset_q: got %h exp 0", q); end
    total++;
    if ({load_ready, busy, tc} !== 3'b100) begin
      bad++;
      $display("FAIL async_reset_flags: got lr/busy/tc=%b/%b/%b exp 1/0/0", load_ready, busy, tc);
    end
    @(negedge clk);
    rst_ = 1'b1;
    tick();
  endtask

`ifdef PARAM_TIMER_RELOAD_EN
  task automatic test_reload();
    logic [EW-1:0] e;
    int i = 0;
    step(1'b1, 32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4);
    repeat (2) begin
      for (int v = 3; v >= 1; v--) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(v));
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd4);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3);
    step(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3);
    repeat (2) begin
      for (int v = 2; v >= 1; v--) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(v));
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if ({load_ready, busy, tc, q} !== e) begin
        bad++;
        $display("FAIL reload step %0d: got lr/busy/tc/q=%b/%b/%b/%h exp %b/%b/%b/%h",
                 i, load_ready, busy, tc, q, e[EW-1], e[EW-2], e[EW-3], e[W-1:0]);
      end
      i++;
    end
  endtask
`endif

  // Sequence and final report
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
`ifdef PARAM_TIMER_RELOAD_EN
    test_borrow();
    test_async_reset();
    test_reload();
`else
    test_count5();
    test_borrow();
    test_pause();
    test_edges();
    test_async_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_down_timer.md
Name: param_down_timer

Overview:
- Loadable, parameterized down-counter/timer; the count-down counterpart of the team's free-running segmented up-counter.
- Count register is built from cascaded SEG_W-bit segments. Segment k decrements only when all lower segments are zero (borrow chain, evaluated from the registered segment values).
- Software or a sequencer loads a value through a valid/ready handshake, starts the count, and may pause it. The block emits a one-cycle terminal-count pulse when the count expires.

Parameters:
- WIDTH, 32, total count width; must be an integer multiple of SEG_W.
- SEG_W, 8, width of each cascaded segment.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_  input  1  asynchronous, active-low reset.
- load_valid  input  1  load request; load_value is valid.
- load_value  input  WIDTH  value to load into the count register.
- load_ready  output  1  block accepts a load this cycle.
- start  input  1  single-cycle request to begin or resume counting.
- stop  input  1  single-cycle request to pause counting.
- q  output  WIDTH  current count, {segment N-1, ..., segment 0}.
- busy  output  1  high while in RUN.
- tc  output  1  terminal-count pulse, one cycle wide.

Behaviour:
- Reset (rst_ low, asynchronous): q=0, state=IDLE, busy=0, tc=0, load_ready=1, reload register=0.
- States: IDLE, RUN, PAUSE. busy=1 only in RUN. load_ready=1 in IDLE and PAUSE, 0 in RUN.
- Load: load_valid && load_ready at a rising edge -> q <= load_value next cycle. State is unchanged (IDLE stays IDLE, PAUSE stays PAUSE). load_valid in RUN is ignored; the requester must hold it until ready.
- Load takes priority over start in the same cycle. The loaded value is used, and the start is evaluated against the new value on the following cycle only if start is still asserted.
- IDLE/PAUSE + start (no stop, no load):
  - q != 0 -> RUN. First decrement occurs on the edge after the RUN entry edge.
  - q == 0 -> start ignored, no tc.
- RUN, each cycle without stop: q <= q - 1 via the segment borrow chain.
  - Segment 0 always decrements.
  - Segment k decrements iff segments 0..k-1 are all zero, wrapping 0 -> all-ones.
  - Net effect is identical to a WIDTH-bit binary decrement.
- Terminal decrement is the RUN cycle with q == 1:
  - q <= 0, state <= IDLE.
  - tc=1 on the next cycle, for exactly one cycle, coincident with q reading 0.
- RUN + stop -> PAUSE. No decrement that cycle and q holds. This includes q == 1: stop wins and no tc is generated.
- start and stop asserted together: stop wins in RUN; in IDLE/PAUSE, the start is ignored.
- stop in IDLE/PAUSE: no effect.
- Latency: load to q = 1 cycle. start to first decrement = 2 edges. Loading N and starting gives tc N+1 cycles after the start edge.
- Reset mid-RUN: immediate return to reset values; any pending tc is lost.

Optional Feature:
- Macro: PARAM_TIMER_RELOAD_EN.
- Defined:
  - A WIDTH-bit reload register captures load_value on every accepted load.
  - On the terminal decrement, if reload != 0: q <= reload, state stays RUN, and tc pulses on the next cycle as normal. Periodic period = reload cycles.
  - If reload == 0: behaviour is the same as without the macro.
  - stop still pauses. Loading in PAUSE updates both q and reload.
- Not defined: no reload register. The terminal decrement always goes to q=0 and IDLE.

Test Plan:
- Reset: hold rst_ low for 3 cycles -> q=0, busy=0, tc=0, load_ready=1; assert rst_ mid-RUN at q=0x10 -> q=0 asynchronously.
- Load 0x00000005, start -> q goes 5,4,3,2,1,0; tc=1 only on the cycle q=0; busy drops on the same cycle; exactly 6 cycles from start edge to tc.
- Load 0x01000000, start -> next value 0x00FFFFFF (borrow ripples through all segments); load 0x00010000 -> next value 0x0000FFFF.
- Load 10, start, stop after 3 decrements (q=7) -> PAUSE, q holds at 7 for 20 cycles, load_ready=1. Restart -> reaches 0 with a single tc. Stop at q=1 -> no tc, q=1.
- Edge cases:
  - start with q=0 -> stays IDLE, no tc.
  - load_valid in RUN -> load_ready=0, q unaffected.
  - start+stop together in RUN -> PAUSE.
- PARAM_TIMER_RELOAD_EN: load 4, start -> tc every 4 cycles, q sequence 4,3,2,1,4,3,... Load 0 in PAUSE and restart -> ignored (q=0). Load 3 in PAUSE -> new period 3.
